// File: rtl/gpu_video_timing.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_video_timing
//  Purpose  : Video timing generator and pixel-fetch sequencer. It produces
//             h/v counters, sync/blank, and per-pixel fetch requests. It
//             realigns the returned RGB with the delayed sync/blank and
//             substitutes a fill colour when a requested pixel arrives late.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_video_timing #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int          FETCH_LAT = 2,
  parameter logic [23:0] UF_COLOR  = 24'hFF00FF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic [23:0] in_rgb,
  input  logic        in_valid,
  output logic [7:0]  out_vga_red,
  output logic [7:0]  out_vga_green,
  output logic [7:0]  out_vga_blue,
  output logic        out_vga_blank,
  output logic        out_vga_hsync,
  output logic        out_vga_vsync,
  output logic        frame_start,
  output logic        line_start,
  output logic        busy,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter end values fit 12 bits; decode bounds can reach 4096 so they
  // are compared in 13 bits against zero-extended counters.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [11:0] h, v, h_next, v_next;
  logic        running;
  logic [12:0] h_ext, v_ext;
  logic        active, hs, vs;
  logic [2:0]  stage0;   // {active, hs, vs} for the current counters
  logic [2:0]  stage_d;  // same tuple, FETCH_LAT cycles later
  logic [23:0] rgb;

  // State and counter registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_next;
      h     <= h_next;
      v     <= v_next;
    end
  end

  // Next state and counter advance; scan-out only stops at the frame end.
  always_comb begin
    state_next = state;
    h_next     = h;
    v_next     = v;
    case (state)
      ST_IDLE: begin
        h_next = '0;
        v_next = '0;
        if (enable) state_next = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (h == H_LAST) begin
          h_next = '0;
          v_next = (v == V_LAST) ? 12'd0 : v + 12'd1;
        end else begin
          h_next = h + 12'd1;
        end
        if (state == ST_RUN) begin
          if (!enable) state_next = ST_DRAIN;
        end else if (enable) begin
          state_next = ST_RUN;
        end else if (h == H_LAST && v == V_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        h_next     = '0;
        v_next     = '0;
      end
    endcase
  end

  // Stage 0 decode straight from the counter registers.
  assign running = (state != ST_IDLE);
  assign h_ext   = {1'b0, h};
  assign v_ext   = {1'b0, v};
  assign active  = running && (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs      = running && (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs      = running && (v_ext >= VS_START) && (v_ext < VS_END);
  assign stage0  = {active, hs, vs};

  assign pix_req     = active;
  assign pix_x       = h;
  assign pix_y       = v;
  assign frame_start = (state == ST_RUN) && (h == 12'd0) && (v == 12'd0);
  assign line_start  = running && (h == 12'd0);
  assign busy        = running;

  // Delay line that matches the framebuffer fetch latency.
  generate
    if (FETCH_LAT == 0) begin : g_no_delay
      assign stage_d = stage0;
    end else begin : g_delay
      logic [2:0] pipe [FETCH_LAT];
      // Shift every cycle; reset fills it with blank, sync-deasserted entries.
      always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < FETCH_LAT; i++) pipe[i] <= 3'b000;
        end else begin
          pipe[0] <= stage0;
          for (int i = 1; i < FETCH_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign stage_d = pipe[FETCH_LAT-1];
    end
  endgenerate

  // Output register: realigned sync/blank plus pixel data or fill colour.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb           <= '0;
      out_vga_blank <= 1'b1;
      out_vga_hsync <= ~HS_POL;
      out_vga_vsync <= ~VS_POL;
    end else begin
      out_vga_blank <= ~stage_d[2];
      out_vga_hsync <= stage_d[1] ? HS_POL : ~HS_POL;
      out_vga_vsync <= stage_d[0] ? VS_POL : ~VS_POL;
      if (!stage_d[2])   rgb <= '0;
      else if (in_valid) rgb <= in_rgb;
      else               rgb <= UF_COLOR;
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                          underflow <= 1'b0;
    else if (stage_d[2] && !in_valid) underflow <= 1'b1;
    else if (underflow_clr)           underflow <= 1'b0;
  end

  assign out_vga_red   = rgb[23:16];
  assign out_vga_green = rgb[15:8];
  assign out_vga_blue  = rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_gpu_video_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_video_timing
//  Purpose  : Self-checking bench for gpu_video_timing on a tiny 8x6 raster.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpu_video_timing;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam logic HSP = 1'b0, VSP = 1'b0;
  localparam logic [23:0] UF = 24'hFF00FF;

  logic        pclk, rst, enable, in_valid, underflow_clr;
  logic [23:0] in_rgb;
  logic        pix_req, out_vga_blank, out_vga_hsync, out_vga_vsync;
  logic        frame_start, line_start, busy, underflow;
  logic [11:0] pix_x, pix_y;
  logic [7:0]  out_vga_red, out_vga_green, out_vga_blue;

  gpu_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .FETCH_LAT(LAT), .UF_COLOR(UF)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .in_rgb(in_rgb), .in_valid(in_valid),
    .out_vga_red(out_vga_red), .out_vga_green(out_vga_green), .out_vga_blue(out_vga_blue),
    .out_vga_blank(out_vga_blank), .out_vga_hsync(out_vga_hsync), .out_vga_vsync(out_vga_vsync),
    .frame_start(frame_start), .line_start(line_start), .busy(busy),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [27:0] s0_bus, out_bus;
  assign s0_bus  = {pix_req, pix_x, pix_y, frame_start, line_start, busy};
  assign out_bus = {out_vga_blank, out_vga_hsync, out_vga_vsync,
                    out_vga_red, out_vga_green, out_vga_blue, underflow};

  // Reference model: scan position is a linear pixel index into the frame.
  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
  } ent_t;

  int          mstate;   // 0 idle, 1 run, 2 drain
  int          pos;
  ent_t        q[$];     // stage-0 history still in flight
  logic        e_blank, e_hsp, e_vsp, e_uf;
  logic [23:0] e_rgb;
  int          vmode;    // 0 always valid, 1 random valid
  int          force_x, force_y;
  int          vectors, miscompares;

  function automatic ent_t stage0_now();
    ent_t e;
    int   h = pos % HT;
    int   v = pos / HT;
    bit   run = (mstate != 0);
    e.act = run && h < HA && v < VA;
    e.hs  = run && h >= HA + HF && h < HA + HF + HSW;
    e.vs  = run && v >= VA + VF && v < VA + VF + VSW;
    e.x   = 12'(h);
    e.y   = 12'(v);
    return e;
  endfunction

  function automatic logic [27:0] exp_s0();
    ent_t e = stage0_now();
    bit   run = (mstate != 0);
    return {e.act, e.x, e.y, (mstate == 1 && pos == 0), (run && (pos % HT) == 0), run};
  endfunction

  function automatic logic [27:0] exp_out();
    return {e_blank, e_hsp, e_vsp, e_rgb, e_uf};
  endfunction

  task automatic model_reset();
    ent_t z = '0;
    mstate = 0;
    pos    = 0;
    q.delete();
    for (int i = 0; i < LAT; i++) q.push_back(z);
    e_blank = 1'b1; e_hsp = !HSP; e_vsp = !VSP; e_rgb = '0; e_uf = 1'b0;
  endtask

  // Framebuffer emulation: answer the request made LAT cycles ago.
  task automatic drive_inputs();
    ent_t f = q[0];
    in_rgb   = {f.x[7:0], f.y[7:0], (vmode == 0) ? 8'h00 : 8'($urandom)};
    in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (f.act && int'(f.x) == force_x && int'(f.y) == force_y) in_valid = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic tick();
    ent_t cur, old;
    if (rst) begin
      @(posedge pclk); #1;
      return;
    end
    cur = stage0_now();
    q.push_back(cur);
    old = q.pop_front();
    e_blank = !old.act;
    e_hsp   = old.hs ? HSP : !HSP;
    e_vsp   = old.vs ? VSP : !VSP;
    e_rgb   = !old.act ? 24'h0 : (in_valid ? in_rgb : UF);
    if (old.act && !in_valid) e_uf = 1'b1;
    else if (underflow_clr)   e_uf = 1'b0;
    case (mstate)
      0: begin
        pos = 0;
        if (enable) mstate = 1;
      end
      1: begin
        if (!enable) mstate = 2;
        pos = (pos + 1) % FRAME;
      end
      default: begin
        if (enable) mstate = 1;
        else if (pos == FRAME - 1) mstate = 0;
        pos = (pos + 1) % FRAME;
      end
    endcase
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; underflow_clr = 1'b0; in_valid = 1'b0; in_rgb = '0;
    vmode = 0; force_x = -1; force_y = -1;
    model_reset();
    #1;
    vectors++;
    if (out_bus !== exp_out()) begin
      miscompares++;
      $display("FAIL reset_out: got %h want %h", out_bus, exp_out());
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      drive_inputs();
      tick();
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL idle_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL idle_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
  endtask

  task automatic test_scan();
    int fs_count = 0;
    enable = 1'b1; vmode = 0;
    for (int c = 0; c < 2 * FRAME + 5; c++) begin
      drive_inputs();
      tick();
      if (frame_start === 1'b1) fs_count++;
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL scan_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL scan_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
    // First RUN cycle plus two wraps fall inside this window.
    vectors++;
    if (fs_count !== 3) begin
      miscompares++;
      $display("FAIL scan_frame_count: got %0d want 3", fs_count);
    end
  endtask

  task automatic test_underflow();
    enable = 1'b1; vmode = 0; force_x = 2; force_y = 1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      drive_inputs();
      underflow_clr = (c == FRAME + 20);
      if (c >= 2 * FRAME && q[0].act && !in_valid) underflow_clr = 1'b1;
      tick();
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL uf_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL uf_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
    underflow_clr = 1'b0;
    // The final frame only ever cleared on the same cycle as a new underflow.
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL uf_set_wins: got %b want 1", underflow);
    end
    force_x = -1; force_y = -1;
  endtask

  task automatic test_drain();
    int c;
    enable = 1'b1; vmode = 1;
    for (c = 0; c < 3 * FRAME && !(mstate == 1 && pos == HT * 2 + 1); c++) begin
      drive_inputs();
      tick();
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL drain_pre_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
    vectors++;
    if ({pix_x, pix_y} !== {12'd1, 12'd2}) begin
      miscompares++;
      $display("FAIL drain_reach: got (%0d,%0d) want (1,2)", pix_x, pix_y);
    end
    enable = 1'b0;
    for (c = 0; c < 2 * FRAME && mstate != 0; c++) begin
      drive_inputs();
      tick();
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL drain_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL drain_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
    for (c = 0; c < 10; c++) begin
      drive_inputs();
      tick();
    end
    vectors++;
    if ({busy, out_vga_blank, out_vga_red} !== {1'b0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL drain_idle: got busy=%b blank=%b red=%h want 0/1/00",
               busy, out_vga_blank, out_vga_red);
    end
    // Re-enable part-way through a drain: scanning must just carry on.
    enable = 1'b1;
    for (c = 0; c < 2 * FRAME + 30; c++) begin
      if (c == 30) enable = 1'b0;
      if (c == 35) enable = 1'b1;
      drive_inputs();
      tick();
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL redrain_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL redrain_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
  endtask

  task automatic test_midreset();
    int c;
    enable = 1'b1; vmode = 0;
    for (c = 0; c < 3 * FRAME && !(mstate == 1 && pos == HT + 2); c++) begin
      drive_inputs();
      tick();
    end
    drive_inputs();
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (s0_bus !== exp_s0()) begin
      miscompares++;
      $display("FAIL midrst_s0: got %h want %h", s0_bus, exp_s0());
    end
    vectors++;
    if (out_bus !== exp_out()) begin
      miscompares++;
      $display("FAIL midrst_out: got %h want %h", out_bus, exp_out());
    end
    tick();
    tick();
    rst = 1'b0;
    for (c = 0; c < FRAME + 5; c++) begin
      drive_inputs();
      tick();
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL postrst_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL postrst_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
  endtask

  task automatic test_random();
    vmode = 1;
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      underflow_clr = ($urandom_range(0, 15) == 0);
      drive_inputs();
      tick();
      vectors++;
      if (s0_bus !== exp_s0()) begin
        miscompares++;
        $display("FAIL rand_s0 c=%0d: got %h want %h", c, s0_bus, exp_s0());
      end
      vectors++;
      if (out_bus !== exp_out()) begin
        miscompares++;
        $display("FAIL rand_out c=%0d: got %h want %h", c, out_bus, exp_out());
      end
    end
    underflow_clr = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_scan();
    test_underflow();
    test_drain();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
